// File: rtl/dcpu_prefetch.sv
// Wishbone-read prefetcher with a halfword queue assembling 16/32/48-bit instructions.
// Flush during a pending read aborts it when DCPU_PREFETCH_ABORT_EN is defined, otherwise drains it.
module dcpu_prefetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  output logic [31:0] o_wb_addr,
  output logic        o_wb_cyc,
  output logic [3:0]  o_wb_stb,
  output logic        o_wb_we,
  input  logic [31:0] i_wb_dat,
  input  logic        i_wb_ack,
  input  logic        i_wb_err,
  input  logic        i_flush,
  input  logic [31:0] i_pc,
  output logic [47:0] o_instruction,
  output logic [1:0]  o_len,
  output logic [31:0] o_pc,
  output logic        o_valid,
  input  logic        i_ready,
  output logic        o_error
);

  localparam int HW = 2 * DEPTH;
  localparam int PW = $clog2(HW);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   mem_q [HW];
  logic [PW-1:0] head_q, head_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   fetch_q, fetch_d;
  logic [31:0]   addr_q, addr_d;
  logic          skip_q, skip_d;
  logic          err_q, err_d;

  logic [15:0]   h0, h1, h2;
  logic [1:0]    len;
  logic [CW-1:0] len_w;
  logic          pop;
  logic [CW-1:0] pop_n;
  logic [CW-1:0] push_n;
  logic [CW-1:0] free_after_pop;
  logic          ack_ok;
  logic          push_lo, push_hi;
  logic [PW-1:0] tail;
  logic          unused_pc0;

  assign unused_pc0 = i_pc[0];

  assign h0 = mem_q[head_q];
  assign h1 = mem_q[head_q + PW'(1)];
  assign h2 = mem_q[head_q + PW'(2)];

  always_comb begin
    len = 2'd3;
    if (!h0[15]) begin
      len = 2'd1;
    end else if (!h0[14]) begin
      len = 2'd2;
    end
  end

  assign len_w          = CW'(len);
  assign o_len          = len;
  assign o_valid        = (count_q >= len_w);
  assign o_instruction  = {(len == 2'd3) ? h2 : 16'h0000,
                           (len != 2'd1) ? h1 : 16'h0000,
                           h0};
  assign o_pc           = pc_q;
  assign o_error        = err_q;

  assign pop            = o_valid && i_ready && !i_flush;
  assign pop_n          = pop ? len_w : '0;
  assign free_after_pop = CW'(HW) - count_q + pop_n;

  // A completing read only lands in the queue if no redirect arrives on the same edge.
  assign ack_ok  = (state_q == S_READ) && i_wb_ack && !i_wb_err && !i_flush;
  assign push_lo = ack_ok && !skip_q;
  assign push_hi = ack_ok;
  assign push_n  = CW'(push_lo) + CW'(push_hi);
  assign tail    = head_q + count_q[PW-1:0];

  always_comb begin
    head_d  = head_q;
    count_d = count_q;
    pc_d    = pc_q;
    fetch_d = fetch_q;
    skip_d  = skip_q;
    err_d   = err_q;
    if (i_flush) begin
      head_d  = '0;
      count_d = '0;
      pc_d    = {i_pc[31:1], 1'b0};
      fetch_d = {i_pc[31:2], 2'b00};
      skip_d  = i_pc[1];
      err_d   = 1'b0;
    end else begin
      head_d  = head_q + pop_n[PW-1:0];
      count_d = count_q - pop_n + push_n;
      if (pop) begin
        pc_d = pc_q + 32'({len, 1'b0});
      end
      if (ack_ok) begin
        fetch_d = fetch_q + 32'd4;
        skip_d  = 1'b0;
      end
      if ((state_q == S_READ) && i_wb_err) begin
        err_d = 1'b1;
      end
    end
  end

  // Reads issue only from IDLE, so the two-halfword space check at issue covers the push.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      S_IDLE: begin
        if (i_flush) begin
          state_d = S_READ;
          addr_d  = {i_pc[31:2], 2'b00};
        end else if (!err_q && (free_after_pop >= CW'(2))) begin
          state_d = S_READ;
          addr_d  = fetch_q;
        end
      end
      S_READ: begin
        if (i_wb_ack || i_wb_err) begin
          state_d = S_IDLE;
        end else if (i_flush) begin
`ifdef DCPU_PREFETCH_ABORT_EN
          state_d = S_IDLE;
`else
          state_d = S_DRAIN;
`endif
        end
      end
      S_DRAIN: begin
        if (i_wb_ack || i_wb_err) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      head_q  <= '0;
      count_q <= '0;
      pc_q    <= RESET_PC;
      fetch_q <= {RESET_PC[31:2], 2'b00};
      addr_q  <= {RESET_PC[31:2], 2'b00};
      skip_q  <= RESET_PC[1];
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      count_q <= count_d;
      pc_q    <= pc_d;
      fetch_q <= fetch_d;
      addr_q  <= addr_d;
      skip_q  <= skip_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < HW; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_lo) begin
      mem_q[tail]          <= i_wb_dat[15:0];
      mem_q[tail + PW'(1)] <= i_wb_dat[31:16];
    end else if (push_hi) begin
      mem_q[tail] <= i_wb_dat[31:16];
    end
  end

  assign o_wb_addr = addr_q;
  assign o_wb_cyc  = (state_q != S_IDLE);
  assign o_wb_stb  = o_wb_cyc ? 4'hF : 4'h0;
  assign o_wb_we   = 1'b0;

endmodule

// File: tb/tb_dcpu_prefetch.sv
// Bench for dcpu_prefetch: address-hashed memory, randomized ack latency and consumer,
// instruction stream predicted from memory contents and compared on every pop.
module tb_dcpu_prefetch;

  logic        clk = 1'b0;
  logic        i_reset;
  logic [31:0] o_wb_addr;
  logic        o_wb_cyc;
  logic [3:0]  o_wb_stb;
  logic        o_wb_we;
  logic [31:0] i_wb_dat;
  logic        i_wb_ack;
  logic        i_wb_err;
  logic        i_flush;
  logic [31:0] i_pc;
  logic [47:0] o_instruction;
  logic [1:0]  o_len;
  logic [31:0] o_pc;
  logic        o_valid;
  logic        i_ready;
  logic        o_error;

  always #5 clk = ~clk;

  dcpu_prefetch #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .i_clk(clk), .i_reset(i_reset),
    .o_wb_addr(o_wb_addr), .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
    .i_wb_dat(i_wb_dat), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err),
    .i_flush(i_flush), .i_pc(i_pc),
    .o_instruction(o_instruction), .o_len(o_len), .o_pc(o_pc), .o_valid(o_valid),
    .i_ready(i_ready), .o_error(o_error)
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [47:0] ins;
    logic [1:0]  len;
    logic [31:0] pc;
  } exp_t;
  exp_t exp_q[$];

  int          lat_fixed  = 0;
  bit          lat_random = 0;
  logic [31:0] err_addr   = 32'h1;
  int          txn_cnt    = 0;
  logic [31:0] start_log[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] h;
    if (a == 32'h0) return 32'h8001_0002;
    if (a == 32'h4) return 32'h0000_1234;
    h = a * 32'h9E37_79B1;
    h = h ^ (h >> 15);
    h = h * 32'h85EB_CA6B;
    h = h ^ (h >> 13);
    return h;
  endfunction

  function automatic logic [15:0] hw_at(input logic [31:0] a);
    logic [31:0] w;
    w = mem_word({a[31:2], 2'b00});
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  // Expected instruction stream: walk memory halfword by halfword from the start pc.
  task automatic load_model(input logic [31:0] start);
    logic [31:0] p;
    logic [15:0] h;
    int          l;
    exp_t        e;
    exp_q.delete();
    p = start;
    for (int n = 0; n < 80; n++) begin
      h = hw_at(p);
      l = !h[15] ? 1 : (!h[14] ? 2 : 3);
      e.ins = {(l == 3) ? hw_at(p + 32'd4) : 16'h0, (l >= 2) ? hw_at(p + 32'd2) : 16'h0, h};
      e.len = 2'(l);
      e.pc  = p;
      exp_q.push_back(e);
      p = p + 32'(2 * l);
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out waiting", name);
  endtask

  // Bus slave: acks (or errs on err_addr) after a fixed or random wait.
  initial begin
    bit active;
    int left;
    active   = 0;
    left     = 0;
    i_wb_ack = 1'b0;
    i_wb_err = 1'b0;
    i_wb_dat = 32'h0;
    forever begin
      @(negedge clk);
      if (i_wb_ack || i_wb_err) begin
        i_wb_ack = 1'b0;
        i_wb_err = 1'b0;
        active   = 0;
      end else if (!o_wb_cyc || i_reset) begin
        active = 0;
      end else begin
        if (!active) begin
          active = 1;
          left   = lat_random ? $urandom_range(0, 3) : lat_fixed;
          start_log.push_back(o_wb_addr);
        end
        if (left == 0) begin
          if (o_wb_addr == err_addr) begin
            i_wb_err = 1'b1;
          end else begin
            i_wb_ack = 1'b1;
            i_wb_dat = mem_word(o_wb_addr);
          end
          txn_cnt++;
        end else begin
          left--;
        end
      end
    end
  end

  // Monitor: bus-protocol checks each cycle, scoreboard compare on each pop.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (!i_reset) begin
        check("wb_we", 64'(o_wb_we), 64'd0);
        if (o_wb_cyc) begin
          check("wb_stb", 64'(o_wb_stb), 64'hF);
          check("wb_addr_align", 64'(o_wb_addr[1:0]), 64'd0);
        end
        if (o_valid && i_ready && !i_flush) begin
          if (exp_q.size() == 0) begin
            timeout("sb_underflow");
          end else begin
            e = exp_q.pop_front();
            check("instr", 64'(o_instruction), 64'(e.ins));
            check("len", 64'(o_len), 64'(e.len));
            check("pc", 64'(o_pc), 64'(e.pc));
          end
        end
      end
    end
  end

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      #1;
      if (!o_wb_cyc) begin
        ok = 1;
        break;
      end
    end
    if (!ok) timeout("wait_idle");
  endtask

  // Called at negedge+1; returns at the following negedge+1 with the flush applied.
  task automatic do_flush(input logic [31:0] pc);
    i_flush = 1'b1;
    i_pc    = pc;
    load_model({pc[31:1], 1'b0});
    @(negedge clk);
    #1;
    i_flush = 1'b0;
  endtask

  task automatic run_cycles(input int n, input bit rnd);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      #1;
      if (rnd) i_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  initial begin
    bit          ok;
    logic [31:0] p;
    i_reset = 1'b1;
    i_flush = 1'b0;
    i_pc    = 32'h0;
    i_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_cyc", 64'(o_wb_cyc), 64'd0);
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_error", 64'(o_error), 64'd0);
    check("rst_pc", 64'(o_pc), 64'd0);
    load_model(32'h0);
    i_reset = 1'b0;

    ok = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #1;
      if (o_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) timeout("first_valid");
    check("first_len", 64'(o_len), 64'd1);
    check("first_instr", 64'(o_instruction), 64'h2);
    check("first_pc", 64'(o_pc), 64'd0);
    i_ready = 1'b1;
    run_cycles(12, 0);
    i_ready = 1'b0;

    // Consumer stalled: the queue takes exactly DEPTH reads.
    wait_idle();
    txn_cnt = 0;
    do_flush(32'h300);
    check("flush_cyc", 64'(o_wb_cyc), 64'd1);
    check("flush_addr", 64'(o_wb_addr), 64'h300);
    check("flush_valid", 64'(o_valid), 64'd0);
    run_cycles(40, 0);
    check("full_reads", 64'(txn_cnt), 64'd4);
    check("full_cyc", 64'(o_wb_cyc), 64'd0);

    // Odd-halfword redirect.
    wait_idle();
    do_flush(32'h106);
    check("skip_addr", 64'(o_wb_addr), 64'h104);
    check("skip_pc", 64'(o_pc), 64'h106);
    run_cycles(30, 1);
    i_ready = 1'b0;

    // Bus error is sticky and blocks reads until a flush.
    wait_idle();
    err_addr = 32'h20;
    txn_cnt  = 0;
    do_flush(32'h20);
    run_cycles(20, 0);
    check("err_set", 64'(o_error), 64'd1);
    check("err_txns", 64'(txn_cnt), 64'd1);
    check("err_cyc", 64'(o_wb_cyc), 64'd0);
    err_addr = 32'h1;
    do_flush(32'h40);
    check("err_clr", 64'(o_error), 64'd0);
    check("err_new_cyc", 64'(o_wb_cyc), 64'd1);
    check("err_new_addr", 64'(o_wb_addr), 64'h40);

    // Redirect while a slow read is outstanding.
    lat_fixed = 3;
    wait_idle();
    do_flush(32'h500);
    check("pend_addr", 64'(o_wb_addr), 64'h500);
    start_log.delete();
    do_flush(32'h200);
`ifdef DCPU_PREFETCH_ABORT_EN
    check("abort_cyc", 64'(o_wb_cyc), 64'd0);
`else
    check("drain_cyc", 64'(o_wb_cyc), 64'd1);
`endif
    ok = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      #1;
      if (start_log.size() > 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) timeout("redirect_read");
    else check("redirect_addr", 64'(start_log[0]), 64'h200);
    check("redirect_err", 64'(o_error), 64'd0);
    lat_fixed = 0;
    run_cycles(30, 1);
    i_ready = 1'b0;

    // Fetch address wraps to zero.
    wait_idle();
    start_log.delete();
    do_flush(32'hFFFF_FFFC);
    run_cycles(20, 0);
    check("wrap_log_size", 64'(start_log.size() >= 2), 64'd1);
    if (start_log.size() >= 2) begin
      check("wrap_addr0", 64'(start_log[0]), 64'hFFFF_FFFC);
      check("wrap_addr1", 64'(start_log[1]), 64'h0);
    end
    run_cycles(20, 1);

    // Random redirects, latencies and consumer stalls.
    lat_random = 1;
    for (int s = 0; s < 120; s++) begin
      p = $urandom;
      if ($urandom_range(0, 3) == 0) p = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      do_flush(p);
      run_cycles($urandom_range(3, 45), 1);
    end

    // Reset in the middle of a read.
    lat_random = 0;
    lat_fixed  = 3;
    i_ready    = 1'b0;
    do_flush(32'h80);
    i_reset = 1'b1;
    @(negedge clk);
    #1;
    check("midrst_cyc", 64'(o_wb_cyc), 64'd0);
    check("midrst_valid", 64'(o_valid), 64'd0);
    check("midrst_pc", 64'(o_pc), 64'd0);
    load_model(32'h0);
    i_reset   = 1'b0;
    lat_fixed = 0;
    run_cycles(30, 1);
    i_ready = 1'b0;
    run_cycles(4, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
